// File: rtl/dmem_pkg.sv
// Shared types and constants for the line data memory model.
// Optional statistics counters are enabled with DMEM_STATS_EN.
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/line_data_memory_if.sv
// Enable/ack line request bus between the dcache controller and memory.
// The master holds enable_i high until it observes ack_o.
interface line_data_memory_if;
    import dmem_pkg::*;

    logic              enable_i;
    logic              write_i;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic [LINE_W-1:0] data_o;
    logic              ack_o;

    modport master (
        output enable_i,
        output write_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  ack_o
    );

    modport slave (
        input  enable_i,
        input  write_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output ack_o
    );

endinterface

// File: rtl/dmem_line_array.sv
// Line storage: synchronous write, registered read port.
// Only the read register is reset; array contents are left as-is.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/line_data_memory.sv
// Fixed-latency 256-bit line memory behind the dcache miss/write-back path.
// Define DMEM_STATS_EN to build the completed read/write counters.
module line_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    line_data_memory_if.slave  bus,
    output logic [31:0]        rd_count_o,
    output logic [31:0]        wr_count_o
);

    state_t            state;
    logic [7:0]        cnt;
    logic              wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              go_done;
    logic              unused_addr;

    assign go_done = (state == BUSY) && (cnt == 8'd0);
    assign bus.ack_o = (state == DONE);

    // Offset and alias bits never select a line.
    assign unused_addr = &{1'b0,
                           bus.addr_i[31:ADDR_W+OFFSET_W],
                           bus.addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.enable_i) begin
                        state   <= BUSY;
                        cnt     <= 8'(LATENCY - 1);
                        wr_q    <= bus.write_i;
                        idx_q   <= bus.addr_i[ADDR_W+OFFSET_W-1:OFFSET_W];
                        wdata_q <= bus.data_i;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_line_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (go_done & wr_q),
        .re    (go_done & ~wr_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (bus.data_o)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (go_done) begin
            if (wr_q) begin
                wr_count_o <= wr_count_o + 32'd1;
            end else begin
                rd_count_o <= rd_count_o + 32'd1;
            end
        end
    end
`else
    assign rd_count_o = 32'd0;
    assign wr_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory with a read-data scoreboard.
// Counter checks follow DMEM_STATS_EN.
module tb_line_data_memory;
    import dmem_pkg::*;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_data_memory_if bus();
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    line_data_memory #(
        .ADDR_W  (10),
        .LATENCY (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .rd_count_o (rd_cnt),
        .wr_count_o (wr_cnt)
    );

    int tests = 0;
    int fails = 0;
    logic [LINE_W-1:0] model [int];
    logic [LINE_W-1:0] exp_q [$];

    task automatic check(input string tag,
                         input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lidx(input logic [31:0] a);
        return int'(a[14:5]);
    endfunction

    // Called at a negedge; returns at the negedge where ack is seen.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.ack_o && n < 300);
    endtask

    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [LINE_W-1:0] d);
        bus.enable_i = 1'b1;
        bus.write_i  = w;
        bus.addr_i   = a;
        bus.data_i   = d;
        if (!w) exp_q.push_back(model[lidx(a)]);
    endtask

    task automatic complete(input logic w, input logic [31:0] a,
                            input logic [LINE_W-1:0] d, input string tag);
        logic [LINE_W-1:0] e;
        if (w) begin
            model[lidx(a)] = d;
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.data_o, e);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [LINE_W-1:0] d, input string tag);
        int n;
        drive(w, a, d);
        wait_ack(n);
        check({tag, "_lat"}, LINE_W'(n), LINE_W'(LAT + 1));
        complete(w, a, d, tag);
        bus.enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack1"}, LINE_W'(bus.ack_o), '0);
    endtask

    logic [LINE_W-1:0] p5a, pa, pb, pc, pold, pnew;
    int n, n2;

    initial begin
        p5a  = {32{8'h5A}};
        pa   = {8{32'hA1B2C3D4}};
        pb   = {8{32'h0BADF00D}};
        pc   = {16{16'h1234}};
        pold = {4{64'h0123456789ABCDEF}};
        pnew = {4{64'hFEDCBA9876543210}};
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;

        repeat (2) @(negedge clk);
        check("rst_ack", LINE_W'(bus.ack_o), '0);
        check("rst_data", bus.data_o, '0);
        check("rst_rd", LINE_W'(rd_cnt), '0);
        check("rst_wr", LINE_W'(wr_cnt), '0);
        rst = 1'b1;
        @(negedge clk);

        xfer(1'b1, 32'h0000_0040, p5a, "t1_wr");
        xfer(1'b0, 32'h0000_0040, '0, "t1_rd");

        xfer(1'b1, 32'h0000_0045, pa, "t2_wr");
        xfer(1'b0, 32'h0000_0040, '0, "t2_rd");
        xfer(1'b0, 32'h0000_8040, '0, "t2_alias");

        xfer(1'b1, 32'h0000_00C0, pc, "t3_pre");
        drive(1'b1, 32'h0000_0080, pb);
        wait_ack(n);
        check("t3_lat", LINE_W'(n), LINE_W'(LAT + 1));
        complete(1'b1, 32'h0000_0080, pb, "t3_wr");
        drive(1'b0, 32'h0000_00C0, '0);
        wait_ack(n2);
        // Back-to-back ack lands LAT+1 edges after the first ack ends.
        check("t3_b2b", LINE_W'(n2 - 1), LINE_W'(LAT + 1));
        complete(1'b0, 32'h0000_00C0, '0, "t3_rd");
        bus.enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        xfer(1'b0, 32'h0000_0080, '0, "t3_chk");

        xfer(1'b1, 32'h0000_0180, pc, "t4_pre");
        drive(1'b1, 32'h0000_0140, pa);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = 32'h0000_0180;
        bus.data_i   = pb;
        wait_ack(n);
        check("t4_lat", LINE_W'(n + 3), LINE_W'(LAT + 1));
        model[lidx(32'h0000_0140)] = pa;
        @(posedge clk);
        @(negedge clk);
        xfer(1'b0, 32'h0000_0140, '0, "t4_rd140");
        xfer(1'b0, 32'h0000_0180, '0, "t4_rd180");

        xfer(1'b1, 32'h0000_0100, pold, "t5_pre");
        xfer(1'b0, 32'h0000_0100, '0, "t5_prerd");
        drive(1'b1, 32'h0000_0100, pnew);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("t5_ack", LINE_W'(bus.ack_o), '0);
        check("t5_data", bus.data_o, '0);
        bus.enable_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t5_noack", LINE_W'(bus.ack_o), '0);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t5_idle", LINE_W'(bus.ack_o), '0);
        end
        xfer(1'b0, 32'h0000_0100, '0, "t5_rd");

        xfer(1'b1, 32'h0000_0200, pa, "t6_w1");
        xfer(1'b1, 32'h0000_0220, pb, "t6_w2");
        xfer(1'b1, 32'h0000_0240, pc, "t6_w3");
        xfer(1'b0, 32'h0000_0220, '0, "t6_rd");
`ifdef DMEM_STATS_EN
        check("t6_rdcnt", LINE_W'(rd_cnt), LINE_W'(2));
        check("t6_wrcnt", LINE_W'(wr_cnt), LINE_W'(3));
`else
        check("t6_rdcnt", LINE_W'(rd_cnt), '0);
        check("t6_wrcnt", LINE_W'(wr_cnt), '0);
`endif
        check("sb_empty", LINE_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
